// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, serial and parallel data bundle of the universal shift register
interface univ_shift_reg_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic             en_i;
  logic [2:0]       mode_i;
  logic             start_i;
  logic [CNT_W-1:0] shift_cnt_i;
  logic             abort_i;
  logic             ser_in_l_i;
  logic             ser_in_r_i;
  logic [WIDTH-1:0] parallel_in_i;
  logic [WIDTH-1:0] parallel_out_o;
  logic             ser_out_l_o;
  logic             ser_out_r_o;
  logic             busy_o;
  logic             done_o;
  modport master (
    output en_i, mode_i, start_i, shift_cnt_i, abort_i, ser_in_l_i, ser_in_r_i, parallel_in_i,
    input  parallel_out_o, ser_out_l_o, ser_out_r_o, busy_o, done_o
  );
  modport slave (
    input  en_i, mode_i, start_i, shift_cnt_i, abort_i, ser_in_l_i, ser_in_r_i, parallel_in_i,
    output parallel_out_o, ser_out_l_o, ser_out_r_o, busy_o, done_o
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal register (load/shift/rotate/ashr/clear) with a counted burst engine
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  univ_shift_reg_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q, op;
  logic             busy_q, done_q, is_shift;
  // the burst replays its latched mode; live mode only matters in IDLE
  assign op = state_q == BURST ? mode_q : bus.mode_i;
  assign is_shift = bus.mode_i inside {[3'd2:3'd6]};
  always_comb begin
    q_d = q_q;
    case (op)
      3'd1: q_d = bus.parallel_in_i;
      3'd2: q_d = {q_q[WIDTH-2:0], bus.ser_in_r_i};
      3'd3: q_d = {bus.ser_in_l_i, q_q[WIDTH-1:1]};
      3'd4: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      3'd5: q_d = {q_q[0], q_q[WIDTH-1:1]};
      3'd6: q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
      3'd7: q_d = '0;
      default: q_d = q_q;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i && is_shift) begin
            if (bus.shift_cnt_i == '0) begin
              done_q <= 1'b1;
            end else begin
              cnt_q   <= bus.shift_cnt_i;
              mode_q  <= bus.mode_i;
              busy_q  <= 1'b1;
              state_q <= BURST;
            end
          end else if (bus.start_i || bus.en_i) begin
            q_q <= q_d;
          end
        end
        default: begin
          if (bus.abort_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            q_q   <= q_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      endcase
    end
  end
  assign bus.parallel_out_o = q_q;
  assign bus.ser_out_l_o    = q_q[WIDTH-1];
  assign bus.ser_out_r_o    = q_q[0];
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed scoreboard bench for univ_shift_reg (WIDTH=8, CNT_W=4)
module tb_univ_shift_reg;
  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  univ_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();
  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask
  task automatic check_now(input exp_t e);
    chk({e.tag, ".q"}, bus.parallel_out_o, e.q);
    chk({e.tag, ".busy"}, {7'd0, bus.busy_o}, {7'd0, e.busy});
    chk({e.tag, ".done"}, {7'd0, bus.done_o}, {7'd0, e.done});
    chk({e.tag, ".sol"}, {7'd0, bus.ser_out_l_o}, {7'd0, e.q[7]});
    chk({e.tag, ".sor"}, {7'd0, bus.ser_out_r_o}, {7'd0, e.q[0]});
  endtask
  // push the expectation for the coming edge, then pop and compare once it has passed
  task automatic cyc(input string tag, input logic [7:0] q, input logic b, input logic d);
    exp_t e;
    e.tag = tag; e.q = q; e.busy = b; e.done = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_now(sb.pop_front());
  endtask
  logic [2:0] ops[6]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [7:0] exps[6] = '{8'h03, 8'h40, 8'h03, 8'hC0, 8'hC0, 8'h00};
  logic [7:0] e;
  exp_t       r;
  initial begin
    bus.en_i = 0; bus.mode_i = 0; bus.start_i = 0; bus.shift_cnt_i = 0; bus.abort_i = 0;
    bus.ser_in_l_i = 0; bus.ser_in_r_i = 0; bus.parallel_in_i = 0;
    #3 reset = 1;
    bus.en_i = 1; bus.mode_i = 3'd1; bus.parallel_in_i = 8'hA5;
    #1;
    r.tag = "rst_async"; r.q = 8'h00; r.busy = 0; r.done = 0;
    check_now(r);
    cyc("rst_held", 8'h00, 0, 0);
    @(negedge clk) reset = 0;
    cyc("load_a5", 8'hA5, 0, 0);
    bus.ser_in_r_i = 1; bus.ser_in_l_i = 0;
    for (int i = 0; i < 6; i++) begin
      bus.mode_i = 3'd1; bus.parallel_in_i = 8'h81;
      cyc("ld81", 8'h81, 0, 0);
      bus.mode_i = ops[i];
      cyc($sformatf("op%0d", ops[i]), exps[i], 0, 0);
    end
    bus.mode_i = 3'd1; bus.parallel_in_i = 8'hB4; bus.ser_in_r_i = 0;
    cyc("ld_b4", 8'hB4, 0, 0);
    bus.en_i = 0; bus.start_i = 1; bus.mode_i = 3'd2; bus.shift_cnt_i = 4'd3;
    cyc("shl_acc", 8'hB4, 1, 0);
    bus.start_i = 0; bus.en_i = 1; bus.mode_i = 3'd1; bus.parallel_in_i = 8'hFF;
    cyc("shl_b1", 8'h68, 1, 0);
    cyc("shl_b2", 8'hD0, 1, 0);
    cyc("shl_b3", 8'hA0, 0, 1);
    bus.en_i = 0;
    cyc("shl_post", 8'hA0, 0, 0);
    bus.en_i = 1; bus.mode_i = 3'd1; bus.parallel_in_i = 8'h12;
    cyc("ld_12", 8'h12, 0, 0);
    bus.en_i = 0; bus.start_i = 1; bus.mode_i = 3'd4; bus.shift_cnt_i = 4'd10;
    cyc("rot_acc", 8'h12, 1, 0);
    bus.start_i = 0;
    e = 8'h12;
    for (int i = 1; i <= 10; i++) begin
      e = {e[6:0], e[7]};
      cyc($sformatf("rot_b%0d", i), e, i < 10, i == 10);
    end
    chk("rot_final", bus.parallel_out_o, 8'h48);
    bus.en_i = 1; bus.mode_i = 3'd1; bus.parallel_in_i = 8'hF0;
    cyc("ld_f0", 8'hF0, 0, 0);
    bus.en_i = 0; bus.start_i = 1; bus.mode_i = 3'd3; bus.shift_cnt_i = 4'd5; bus.ser_in_l_i = 0;
    cyc("shr_acc", 8'hF0, 1, 0);
    bus.start_i = 0;
    cyc("shr_b1", 8'h78, 1, 0);
    bus.abort_i = 1;
    cyc("abort", 8'h78, 0, 0);
    bus.abort_i = 0;
    cyc("abort_post", 8'h78, 0, 0);
    bus.start_i = 1; bus.shift_cnt_i = 4'd0;
    cyc("zero_cnt", 8'h78, 0, 1);
    bus.start_i = 0;
    cyc("zero_post", 8'h78, 0, 0);
    bus.en_i = 1; bus.mode_i = 3'd1; bus.parallel_in_i = 8'h80;
    cyc("ld_80", 8'h80, 0, 0);
    bus.en_i = 0; bus.start_i = 1; bus.mode_i = 3'd6; bus.shift_cnt_i = 4'd8;
    cyc("ashr_acc", 8'h80, 1, 0);
    bus.start_i = 0;
    cyc("ashr_b1", 8'hC0, 1, 0);
    cyc("ashr_b2", 8'hE0, 1, 0);
    #1 reset = 1;
    #1;
    r.tag = "rst_mid"; r.q = 8'h00; r.busy = 0; r.done = 0;
    check_now(r);
    @(negedge clk) reset = 0;
    bus.start_i = 1; bus.mode_i = 3'd2; bus.shift_cnt_i = 4'd2; bus.ser_in_r_i = 1;
    cyc("re_acc", 8'h00, 1, 0);
    bus.start_i = 0;
    cyc("re_b1", 8'h01, 1, 0);
    cyc("re_b2", 8'h03, 0, 1);
    cyc("re_post", 8'h03, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
